// File: rtl/col_drain_arbiter.sv
// Round-robin drain of COLS column result controllers into a single one-entry output register.
// Optional `SYSTOLA_DRAIN_STALLCNT_EN adds a saturating stall_cnt output.
module col_drain_arbiter #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  parameter int CW       = $clog2(COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OUTWIDTH-1:0] col_r [0:COLS-1],
  input  logic [COLS-1:0]     col_v,
  output logic [COLS-1:0]     col_rread,
  output logic [OUTWIDTH-1:0] out_data,
  output logic [CW-1:0]       out_col,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef SYSTOLA_DRAIN_STALLCNT_EN
  output logic [15:0]         stall_cnt,
`endif
  output logic                tile_done
);

  localparam int CNTW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ROWS * COLS - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [COLS-1:0] ONE_COL  = {{(COLS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   LAST_RST = CW'(COLS - 1);

  logic [OUTWIDTH-1:0] out_data_r;
  logic [CW-1:0]       out_col_r;
  logic                out_valid_r;
  logic                tile_done_r;
  logic [CW-1:0]       last_grant_r;
  logic [CNTW-1:0]     acc_cnt_r;

  logic                gnt_found_s;
  logic [CW-1:0]       gnt_idx_s;
  logic [CW-1:0]       probe_s;
  logic                slot_free_s;
  logic                grant_s;
  logic                accept_s;

  // Round-robin search starting one past the last granted column.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    probe_s     = '0;
    for (int i = 1; i <= COLS; i++) begin
      probe_s = CW'((int'(last_grant_r) + i) % COLS);
      if (!gnt_found_s && col_v[probe_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = probe_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign slot_free_s = !out_valid_r || out_ready;
  assign accept_s    = out_valid_r && out_ready;
  assign grant_s     = !rst && en && slot_free_s && gnt_found_s;

  // One-hot read strobe to the granted column, same cycle as the grant.
  always_comb begin
    col_rread = '0;
    if (grant_s) begin
      col_rread = ONE_COL << gnt_idx_s;
    end else begin
      col_rread = '0;
    end
  end

  // Output register: reload on grant, empty on accept without grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r   <= '0;
      out_col_r    <= '0;
      out_valid_r  <= 1'b0;
      last_grant_r <= LAST_RST;
    end else if (grant_s) begin
      out_data_r   <= col_r[gnt_idx_s];
      out_col_r    <= gnt_idx_s;
      out_valid_r  <= 1'b1;
      last_grant_r <= gnt_idx_s;
    end else if (accept_s) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  // Accept counter; the accept that completes a tile wraps it and pulses tile_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_r   <= '0;
      tile_done_r <= 1'b0;
    end else if (accept_s && (acc_cnt_r == CNT_LAST)) begin
      acc_cnt_r   <= '0;
      tile_done_r <= 1'b1;
    end else if (accept_s) begin
      acc_cnt_r   <= acc_cnt_r + CNT_ONE;
      tile_done_r <= 1'b0;
    end else begin
      tile_done_r <= 1'b0;
    end
  end

`ifdef SYSTOLA_DRAIN_STALLCNT_EN
  logic [15:0] stall_cnt_r;

  // Cycles the consumer back-pressured a held word; restarts each tile.
  always_ff @(posedge clk) begin
    if (rst || tile_done_r) begin
      stall_cnt_r <= 16'd0;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign out_data  = out_data_r;
  assign out_col   = out_col_r;
  assign out_valid = out_valid_r;
  assign tile_done = tile_done_r;

endmodule

// File: tb/tb_col_drain_arbiter.sv
// Randomised self-checking bench for col_drain_arbiter against a priority-distance reference model.
module tb_col_drain_arbiter;
  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int W    = 32;
  localparam int TILE = ROWS * COLS;

  logic          clk;
  logic          rst;
  logic          en;
  logic [W-1:0]  col_r [0:COLS-1];
  logic [7:0]    col_v;
  logic [7:0]    col_rread;
  logic [W-1:0]  out_data;
  logic [2:0]    out_col;
  logic          out_valid;
  logic          out_ready;
  logic          tile_done;
`ifdef SYSTOLA_DRAIN_STALLCNT_EN
  logic [15:0]   stall_cnt;
`endif

  col_drain_arbiter #(.COLS(COLS), .ROWS(ROWS), .OUTWIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .col_r(col_r), .col_v(col_v),
    .col_rread(col_rread), .out_data(out_data), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef SYSTOLA_DRAIN_STALLCNT_EN
    .stall_cnt(stall_cnt),
`endif
    .tile_done(tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_col;
  int           m_last;
  int           m_acc;
  logic         m_tile;
  int           m_stall;
  logic         p_grant;
  logic         p_accept;
  int           p_gidx;
  logic [7:0]   exp_rread;

  // nearest requesting column measured as distance after the last grant
  function automatic int pick(input logic [7:0] v, input int last);
    int best_d;
    int best;
    int d;
    best_d = COLS;
    best = -1;
    for (int c = 0; c < COLS; c++) begin
      if (v[c]) begin
        d = (c - last - 1 + 2 * COLS) % COLS;
        if (d < best_d) begin
          best_d = d;
          best = c;
        end
      end
    end
    return best;
  endfunction

  task automatic apply(input logic r, input logic e, input logic [7:0] v, input logic rdy);
    int g;
    rst = r; en = e; col_v = v; out_ready = rdy;
    p_accept = m_valid && rdy;
    g = pick(v, m_last);
    p_grant = !r && e && (!m_valid || rdy) && (g >= 0);
    p_gidx = (g < 0) ? 0 : g;
    exp_rread = p_grant ? (8'h01 << g) : 8'h00;
    #1;
  endtask

  task automatic clock();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_col = 0; m_last = COLS - 1;
      m_acc = 0; m_tile = 1'b0; m_stall = 0;
    end else begin
      if (m_tile) m_stall = 0;
      else if (m_valid && !out_ready && m_stall < 65535) m_stall++;
      m_tile = 1'b0;
      if (p_accept) begin
        m_acc++;
        if (m_acc % TILE == 0) m_tile = 1'b1;
      end
      if (p_grant) begin
        m_valid = 1'b1; m_data = col_r[p_gidx]; m_col = p_gidx; m_last = p_gidx;
      end else if (p_accept) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 8'h00, 1'b0);
    clock();
    apply(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic fill_cols();
    for (int c = 0; c < COLS; c++) col_r[c] = $urandom;
  endtask

  task automatic test_reset();
    fill_cols();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 8'hFF, 1'b1);
      n_cmp++;
      if (col_rread !== 8'h00) begin n_fail++; $display("FAIL reset_rread got %h want 00", col_rread); end
      clock();
    end
    n_cmp++;
    if ({out_valid, tile_done, out_col, out_data} !== {1'b0, 1'b0, 3'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b td=%b col=%0d data=%h want all zero", out_valid, tile_done, out_col, out_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    col_r[0] = 32'hA5;
    apply(1'b0, 1'b1, 8'h01, 1'b1);
    n_cmp++;
    if (col_rread !== 8'h01) begin n_fail++; $display("FAIL single_rread got %h want 01", col_rread); end
    clock();
    n_cmp++;
    if ({out_valid, out_col, out_data} !== {1'b1, 3'd0, 32'hA5}) begin
      n_fail++;
      $display("FAIL single_out got v=%b col=%0d data=%h want v=1 col=0 data=a5", out_valid, out_col, out_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    fill_cols();
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, 1'b1, 8'hFF, 1'b1);
      n_cmp++;
      if (col_rread !== (8'h01 << (i % 8))) begin
        n_fail++; $display("FAIL rr_rread step %0d got %h want %h", i, col_rread, 8'h01 << (i % 8));
      end
      clock();
      n_cmp++;
      if (out_valid !== 1'b1 || out_col !== 3'(i % 8) || out_data !== col_r[i % 8]) begin
        n_fail++; $display("FAIL rr_out step %0d got col=%0d data=%h want col=%0d data=%h", i, out_col, out_data, i % 8, col_r[i % 8]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    do_reset();
    fill_cols();
    apply(1'b0, 1'b1, 8'h10, 1'b0);
    clock();
    held = col_r[4];
    for (int i = 0; i < 5; i++) begin
      fill_cols();
      apply(1'b0, 1'b1, 8'hFF, 1'b0);
      n_cmp++;
      if (col_rread !== 8'h00) begin n_fail++; $display("FAIL stall_rread cycle %0d got %h want 00", i, col_rread); end
      clock();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held || out_col !== 3'd4) begin
        n_fail++; $display("FAIL stall_hold cycle %0d got v=%b data=%h col=%0d want v=1 data=%h col=4", i, out_valid, out_data, out_col, held);
      end
    end
`ifdef SYSTOLA_DRAIN_STALLCNT_EN
    n_cmp++;
    if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
`endif
  endtask

  task automatic test_en_low();
    do_reset();
    fill_cols();
    apply(1'b0, 1'b1, 8'h04, 1'b0);
    clock();
    apply(1'b0, 1'b0, 8'h0F, 1'b1);
    n_cmp++;
    if (col_rread !== 8'h00) begin n_fail++; $display("FAIL en_low_rread got %h want 00", col_rread); end
    clock();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_low_valid got %b want 0", out_valid); end
  endtask

  task automatic run_full(input int cycles, output int pulses, output int at);
    pulses = 0; at = -1;
    for (int i = 0; i < cycles; i++) begin
      fill_cols();
      apply(1'b0, 1'b1, 8'hFF, 1'b1);
      clock();
      n_cmp++;
      if (tile_done !== m_tile) begin n_fail++; $display("FAIL tile_track cycle %0d got %b want %b", i, tile_done, m_tile); end
      if (tile_done === 1'b1) begin pulses++; at = i; end
    end
  endtask

  task automatic test_tile();
    int pulses;
    int at;
    do_reset();
    run_full(67, pulses, at);
    n_cmp++;
    if (pulses !== 1 || at !== 64) begin n_fail++; $display("FAIL tile_once got pulses=%0d at=%0d want 1 at 64", pulses, at); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int at;
    do_reset();
    run_full(31, pulses, at);
    apply(1'b1, 1'b1, 8'hFF, 1'b1);
    n_cmp++;
    if (col_rread !== 8'h00) begin n_fail++; $display("FAIL midrst_rread got %h want 00", col_rread); end
    clock();
    n_cmp++;
    if (out_valid !== 1'b0 || tile_done !== 1'b0) begin n_fail++; $display("FAIL midrst_out got v=%b td=%b want 0 0", out_valid, tile_done); end
    run_full(66, pulses, at);
    n_cmp++;
    if (pulses !== 1 || at !== 64) begin n_fail++; $display("FAIL midrst_tile got pulses=%0d at=%0d want 1 at 64", pulses, at); end
  endtask

  task automatic test_random();
    logic r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      fill_cols();
      r = ($urandom_range(0, 99) == 0);
      apply(r, ($urandom_range(0, 9) != 0), 8'($urandom), ($urandom_range(0, 3) != 0));
      n_cmp++;
      if (col_rread !== exp_rread) begin n_fail++; $display("FAIL rand_rread cycle %0d got %h want %h", i, col_rread, exp_rread); end
      clock();
      n_cmp++;
      if (out_valid !== m_valid || tile_done !== m_tile ||
          (m_valid && (out_data !== m_data || out_col !== 3'(m_col)))) begin
        n_fail++;
        $display("FAIL rand_out cycle %0d got v=%b td=%b col=%0d data=%h want v=%b td=%b col=%0d data=%h",
                 i, out_valid, tile_done, out_col, out_data, m_valid, m_tile, m_col, m_data);
      end
`ifdef SYSTOLA_DRAIN_STALLCNT_EN
      n_cmp++;
      if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rand_stall cycle %0d got %0d want %0d", i, stall_cnt, m_stall); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; col_v = 8'h00; out_ready = 1'b0;
    for (int c = 0; c < COLS; c++) col_r[c] = '0;
    m_valid = 1'b0; m_data = '0; m_col = 0; m_last = COLS - 1;
    m_acc = 0; m_tile = 1'b0; m_stall = 0;
    p_grant = 1'b0; p_accept = 1'b0; p_gidx = 0; exp_rread = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_en_low();
    test_tile();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/col_drain_arbiter.md
COL_DRAIN_ARBITER -- requirements
Module: col_drain_arbiter

Interface
REQ-001 Parameter COLS, default 8: number of column output controllers drained.
REQ-002 Parameter ROWS, default 8: results per column per tile.
REQ-003 Parameter OUTWIDTH, default 32: result word width.
REQ-004 Parameter CW, default $clog2(COLS): column index width.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port en  input  1  drain enable; when low, no new grants.
REQ-008 Port col_r  input  OUTWIDTH x COLS (unpacked [0:COLS-1])  head result of each column controller.
REQ-009 Port col_v  input  COLS  per-column result-valid (column's rvalid).
REQ-010 Port col_rread  output  COLS  one-hot read pulse to the granted column.
REQ-011 Port out_data  output  OUTWIDTH  result word to top level.
REQ-012 Port out_col  output  CW  source column of out_data.
REQ-013 Port out_valid  output  1  out_data/out_col valid.
REQ-014 Port out_ready  input  1  top-level consumer accepts when high with out_valid.
REQ-015 Port tile_done  output  1  one-cycle pulse when the last result of a tile is accepted.

Function
REQ-016 Output register is one entry; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 A slot is free in a cycle when the register is EMPTY, or FULL with out_ready=1.
REQ-018 Grant is issued when en=1, a slot is free, and col_v is nonzero.
REQ-019 Grant selects the first set col_v bit searching round-robin from (last_grant+1) mod COLS upward.
REQ-020 last_grant resets to COLS-1, so column 0 has first priority after reset.
REQ-021 On grant g: col_rread[g]=1 for that cycle only, combinationally; all other bits 0.
REQ-022 On grant g: at the next edge, out_data<=col_r[g], out_col<=g, out_valid<=1, last_grant<=g.
REQ-023 Accept (out_valid & out_ready) without grant: out_valid<=0 at the next edge.
REQ-024 Accept and grant in the same cycle: register reloads; out_valid stays 1, one word per cycle.
REQ-025 FULL with out_ready=0: out_data, out_col, out_valid hold; col_rread=0.
REQ-026 en=0 blocks grants only; a held word can still be accepted.
REQ-027 Accept counter width $clog2(ROWS*COLS); increments on every accept.
REQ-028 On the accept that brings the count to ROWS*COLS: tile_done=1 at the next edge for one cycle; the counter wraps to 0.
REQ-029 col_v bits for non-granted columns are ignored; no column is ever read twice in one cycle.

Reset
REQ-030 With rst=1 at an edge: out_valid=0, out_data=0, out_col=0, tile_done=0, accept counter=0, last_grant=COLS-1.
REQ-031 While rst=1, col_rread=0 regardless of inputs.
REQ-032 Reset mid-tile discards the held word and partial count; no tile_done is generated.

Configuration
REQ-033 Macro SYSTOLA_DRAIN_STALLCNT_EN, when defined, adds output port stall_cnt (16 bits).
REQ-034 stall_cnt increments in each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and clears on rst and on tile_done.
REQ-035 Without the macro, the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-036 After reset, col_v=8'h01, col_r[0]=32'hA5, out_ready=1 -> col_rread=8'h01 in the same cycle; next cycle out_data=32'hA5, out_col=0, out_valid=1.
REQ-037 col_v=8'hFF held, out_ready=1 -> grants in the order 0,1,...,7,0; one col_rread pulse per cycle.
REQ-038 Word held with out_ready=0 for 5 cycles -> out_data stable, col_rread=0 throughout; stall_cnt=5 when the macro is defined.
REQ-039 64 accepts with ROWS=8, COLS=8 -> tile_done pulses exactly once, in the cycle after the 64th accept; the counter restarts at 0.
REQ-040 en=0 with col_v=8'h0F and a held word -> the word is accepted, no new grant, out_valid=0 the next cycle.
REQ-041 rst asserted with out_valid=1 after 30 accepts -> next cycle out_valid=0, counter=0; the following 64 accepts give a single tile_done.
